// File: rtl/frame_pkg.sv
// Shared constants, bank state type and lane-slice helper for the frame packer.
package frame_pkg;

  localparam int N_LANES = 64;
  localparam int IDX_W   = 6;
  localparam int GRP_W   = 7;
  localparam int CNT_W   = IDX_W + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Bit offset of lane k inside a packed frame of o_bw-wide lanes.
  function automatic int lane(input int k, input int o_bw);
    return k * o_bw;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame buffer of the packer: lane storage, EMPTY/FILLING/FULL state,
// latched group and write count. Sequence checking under FRAME_PACKER_IDX_CHECK_EN.
module frame_bank
  import frame_pkg::*;
#(
  parameter int O_BW = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [O_BW-1:0]         i_data,
  input  logic [GRP_W-1:0]        i_grp,
  input  logic                    i_pop,
  output bank_state_t             o_state,
  output logic [O_BW*N_LANES-1:0] o_frame,
  output logic [GRP_W-1:0]        o_grp,
  output logic                    o_done,
  output logic                    o_seq_err
);

  bank_state_t               r_state;
  bank_state_t               w_next;
  logic [O_BW*N_LANES-1:0]   r_frame;
  logic [GRP_W-1:0]          r_grp;
  logic [CNT_W-1:0]          r_cnt;
  logic                      w_ok;
  logic                      w_acc;
  logic                      w_last;

  assign w_last = (i_idx == IDX_W'(N_LANES - 1));

`ifdef FRAME_PACKER_IDX_CHECK_EN
  // An idx 0 sample is always a legal (re)start; anything else must continue the frame.
  assign w_ok = (i_idx == '0) ||
                ((r_state == FILLING) && ({1'b0, i_idx} == r_cnt) && (i_grp == r_grp));
`else
  assign w_ok = 1'b1;
`endif

  assign w_acc = i_wr && (r_state != FULL) && w_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_next;
  end

  // NOTE: w_next is given a default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY:   if (w_acc) w_next = w_last ? FULL : FILLING;
      FILLING: if (w_acc && w_last) w_next = FULL;
      FULL:    if (i_pop) w_next = EMPTY;
      default: w_next = EMPTY;
    endcase
  end

  always_comb begin
    o_state   = r_state;
    o_frame   = r_frame;
    o_grp     = r_grp;
    o_done    = w_acc && w_last;
    o_seq_err = i_wr && (r_state != FULL) && !w_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_grp <= '0;
    end else if (i_pop && (r_state == FULL)) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      if ((r_state == EMPTY) || (i_idx == '0)) begin
        r_cnt <= CNT_W'(1);
        r_grp <= i_grp;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: lane storage has no reset; the bank state gates every use of it,
  // and unwritten lanes deliberately keep stale content.
  always_ff @(posedge clk) begin
    if (w_acc) r_frame[lane(int'(i_idx), O_BW) +: O_BW] <= i_data;
  end

endmodule

// File: rtl/frame_packer.sv
// Double-buffered serial-to-parallel frame packer with valid/ready output.
// Optional sample-sequence checking: define FRAME_PACKER_IDX_CHECK_EN.
module frame_packer
  import frame_pkg::*;
#(
  parameter int I_BW = 14,
  parameter int O_BW = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    di_en,
  input  logic [I_BW-1:0]         data_i,
  input  logic [IDX_W-1:0]        in_group_idx,
  input  logic [GRP_W-1:0]        in_group_num,
  output logic                    do_en,
  input  logic                    do_rdy,
  output logic [O_BW*N_LANES-1:0] data_o,
  output logic [GRP_W-1:0]        out_group_num,
  output logic                    overflow,
  output logic                    idx_err
);

  bank_state_t             w_state [2];
  logic [O_BW*N_LANES-1:0] w_frame [2];
  logic [GRP_W-1:0]        w_grp   [2];
  logic [1:0]              w_done;
  logic [1:0]              w_seq_err;
  logic [1:0]              w_wr;
  logic [1:0]              w_pop_b;
  logic [O_BW-1:0]         w_sext;
  logic                    w_pop;
  logic                    w_nsel;
  logic                    w_nfull;

  logic                    r_fill;
  logic                    r_optr;
  logic                    r_do_en;
  logic [O_BW*N_LANES-1:0] r_data;
  logic [GRP_W-1:0]        r_grp;
  logic                    r_ovf;
  logic                    r_idx_err;

  assign w_sext  = O_BW'($signed(data_i));
  assign w_pop   = r_do_en && do_rdy;
  assign w_wr    = {di_en && r_fill, di_en && !r_fill};
  assign w_pop_b = {w_pop && r_optr, w_pop && !r_optr};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.O_BW(O_BW)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr[b]),
      .i_idx     (in_group_idx),
      .i_data    (w_sext),
      .i_grp     (in_group_num),
      .i_pop     (w_pop_b[b]),
      .o_state   (w_state[b]),
      .o_frame   (w_frame[b]),
      .o_grp     (w_grp[b]),
      .o_done    (w_done[b]),
      .o_seq_err (w_seq_err[b])
    );
  end

  // Output register follows the bank that will be the output bank after this edge.
  assign w_nsel  = w_pop ? !r_optr : r_optr;
  assign w_nfull = (w_state[w_nsel] == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill    <= 1'b0;
      r_optr    <= 1'b0;
      r_do_en   <= 1'b0;
      r_data    <= '0;
      r_grp     <= '0;
      r_ovf     <= 1'b0;
      r_idx_err <= 1'b0;
    end else begin
      if (|w_done) r_fill <= !r_fill;
      if (w_pop)   r_optr <= !r_optr;
      r_do_en <= w_nfull;
      if (w_nfull) begin
        r_data <= w_frame[w_nsel];
        r_grp  <= w_grp[w_nsel];
      end
      if (di_en && (w_state[r_fill] == FULL)) r_ovf <= 1'b1;
      if (|w_seq_err) r_idx_err <= 1'b1;
    end
  end

  assign do_en         = r_do_en;
  assign data_o        = r_data;
  assign out_group_num = r_grp;
  assign overflow      = r_ovf;

`ifdef FRAME_PACKER_IDX_CHECK_EN
  assign idx_err = r_idx_err;
`else
  assign idx_err = 1'b0;
`endif

endmodule
